psram_burst_writer: RTL and testbench

Upstream feeder for `psram_burst_controller`. It accepts a 16-bit valid/ready word stream and buffers it in an internal FIFO. Whenever a full burst is available it drives one fixed-length Wishbone-style write burst (`cyc`/`stb`/`we` held high for exactly `BURST_LEN` cycles) into the controller's slave port, then auto-increments the PSRAM word address. The controller has no acknowledge, so this block guarantees back-to-back beats and a minimum idle gap between bursts.

---
 rtl/psram_burst_writer.sv | 166 ++++++++++++++++
 tb/tb_psram_burst_writer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_burst_writer.sv
// Buffers a 16-bit valid/ready stream and emits fixed-length, gap-separated
// Wishbone-style write bursts with an auto-incrementing PSRAM word address.
module psram_burst_writer #(
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [15:0]                   s_dat_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [15:0]                   start_adr_i,
  input  logic                          start_i,
  input  logic                          flush_i,
  output logic [15:0]                   adr_o,
  output logic [15:0]                   dat_o,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          burst_done_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] BL_L      = LW'(BURST_LEN);
  localparam logic [LW-1:0] LAST_BEAT = LW'(BURST_LEN - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYCLES - 1);
  localparam logic [15:0]   ADR_INC   = 16'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [LW-1:0] nreal_q, nreal_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   ptr_q, ptr_d;
  logic [15:0]   adr_q, adr_d;
  logic [15:0]   dat_q, dat_d;
  logic          cyc_q, cyc_d;
  logic          done_q, done_d;
  logic          flush_q, flush_d;
  logic          push, pop, can_full, can_flush;
  logic [15:0]   head;

  assign s_ready_o = level_q < DEPTH_L;
  assign push      = s_valid_i & s_ready_o;
  assign can_full  = level_q >= BL_L;
  assign can_flush = flush_q & (level_q != '0);
  assign head      = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      beat_q  <= '0;
      nreal_q <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      beat_q  <= beat_d;
      nreal_q <= nreal_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= s_dat_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (can_full || can_flush) state_d = S_BURST;
      S_BURST: if (beat_q == LAST_BEAT)   state_d = S_GAP;
      S_GAP:   if (gap_q == LAST_GAP)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat 0 is registered on the IDLE decision edge so the first word appears
  // together with cyc; beat_q always holds the index of the beat on the bus.
  always_comb begin
    adr_d   = adr_q;
    dat_d   = '0;
    cyc_d   = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    beat_d  = beat_q;
    nreal_d = nreal_q;
    gap_d   = '0;
    ptr_d   = ptr_q;
    flush_d = flush_q;
    unique case (state_q)
      S_IDLE: begin
        if (can_full || can_flush) begin
          adr_d   = ptr_q;
          cyc_d   = 1'b1;
          dat_d   = head;
          pop     = 1'b1;
          beat_d  = '0;
          nreal_d = can_full ? BL_L : level_q;
          if (!can_full) flush_d = 1'b0;
        end else if (flush_q) begin
          flush_d = 1'b0;
        end
      end
      S_BURST: begin
        if (beat_q == LAST_BEAT) begin
          done_d = 1'b1;
          ptr_d  = ptr_q + ADR_INC;
        end else begin
          cyc_d  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_d < nreal_q) begin
            dat_d = head;
            pop   = 1'b1;
          end
        end
      end
      S_GAP:   gap_d = gap_q + 1'b1;
      default: ;
    endcase
    if (start_i) ptr_d = start_adr_i;
    if (flush_i) flush_d = 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign we_o         = cyc_q;
  assign level_o      = level_q;
  assign busy_o       = state_q != S_IDLE;
  assign burst_done_o = done_q;

endmodule

// File: tb/tb_psram_burst_writer.sv
// Self-checking bench: a per-cycle schedule model of bursts plus directed
// literal checks, followed by randomized stream/flush/start traffic.
module tb_psram_burst_writer;

  localparam int BL  = 32;
  localparam int FD  = 64;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_dat = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] start_adr = '0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] adr_o, dat_o;
  logic        cyc_o, stb_o, we_o, busy_o, done_o;
  logic [6:0]  level_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psram_burst_writer #(
    .BURST_LEN (BL),
    .FIFO_DEPTH(FD),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .s_dat_i     (s_dat),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .start_adr_i (start_adr),
    .start_i     (start),
    .flush_i     (flush),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .we_o        (we_o),
    .level_o     (level_o),
    .busy_o      (busy_o),
    .burst_done_o(done_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: each accepted burst becomes a list of per-cycle bus records
  // (BL beats, GAP gap cycles, one idle decision cycle).
  typedef struct packed {logic cyc; logic pop; logic done; logic busy;} rec_t;
  rec_t        plan[$];
  logic [15:0] fq[$];
  logic [15:0] m_ptr = '0;
  logic [15:0] m_adr = '0;
  logic        m_fp = 1'b0;

  always @(posedge clk) begin : model
    rec_t        r;
    logic        pv, ps, pf, acc;
    logic [15:0] pd, pa, e_dat;
    logic        e_cyc, e_done, e_busy;
    int          n;
    pv = s_valid; pd = s_dat; ps = start; pa = start_adr; pf = flush;
    if (!rst_n) begin
      plan.delete(); fq.delete();
      m_ptr = '0; m_adr = '0; m_fp = 1'b0;
      e_cyc = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_dat = '0;
    end else begin
      acc = pv && (fq.size() < FD);
      if (plan.size() == 0) begin
        n = fq.size();
        if (n >= BL || (m_fp && n > 0)) begin
          if (n >= BL) n = BL;
          else m_fp = 1'b0;
          m_adr = m_ptr;
          for (int i = 0; i < BL; i++) plan.push_back('{1'b1, (i < n), 1'b0, 1'b1});
          for (int g = 0; g < GAP; g++) plan.push_back('{1'b0, 1'b0, (g == 0), 1'b1});
          plan.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        end else if (n == 0) begin
          m_fp = 1'b0;
        end
      end
      r = '0;
      if (plan.size() > 0) r = plan.pop_front();
      e_dat = '0;
      if (r.pop) e_dat = fq.pop_front();
      if (r.done) m_ptr = m_ptr + 16'(BL);
      if (ps) m_ptr = pa;
      if (pf) m_fp = 1'b1;
      if (acc) fq.push_back(pd);
      e_cyc = r.cyc; e_done = r.done; e_busy = r.busy;
    end
    #1;
    chk("cyc",   32'(cyc_o),   32'(e_cyc));
    chk("stb",   32'(stb_o),   32'(e_cyc));
    chk("we",    32'(we_o),    32'(e_cyc));
    chk("adr",   32'(adr_o),   32'(m_adr));
    chk("dat",   32'(dat_o),   32'(e_dat));
    chk("done",  32'(done_o),  32'(e_done));
    chk("busy",  32'(busy_o),  32'(e_busy));
    chk("level", 32'(level_o), 32'(fq.size()));
    chk("ready", 32'(s_ready), 32'(fq.size() < FD));
  end

  task automatic push_word(input logic [15:0] v);
    int w;
    @(negedge clk);
    s_valid = 1'b1;
    s_dat   = v;
    w = 0;
    while (!s_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) chk("push_stall", 32'(w), 0);
  endtask

  task automatic wait_cyc(input logic val, input string nm);
    int w;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (cyc_o !== val && w < 2000);
    if (cyc_o !== val) chk(nm, 32'(cyc_o), 32'(val));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy_o !== 1'b0 && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    if (busy_o !== 1'b0) chk("idle_timeout", 32'(busy_o), 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      wait_idle();
      if (level_o == 0) break;
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      repeat (2) @(posedge clk);
    end
    #1;
    chk("drain_level", 32'(level_o), 0);
  endtask

  initial begin
    logic [15:0] a1, a2;
    int          low, beats, nz, highs;
    logic        seen_full, push_done;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_level", 32'(level_o), 0);
    rst_n = 1'b1;

    // Single full burst at 0x1234
    @(negedge clk); start = 1'b1; start_adr = 16'h1234;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk); start = 1'b0; s_valid = 1'b1; s_dat = 16'(i);
    end
    @(negedge clk); s_valid = 1'b0;
    chk("t1_cyc_pre", 32'(cyc_o), 0);
    chk("t1_level32", 32'(level_o), 32);
    @(posedge clk); #1;
    chk("t1_cyc_rise", 32'(cyc_o), 1);
    chk("t1_adr", 32'(adr_o), 32'h1234);
    chk("t1_dat1", 32'(dat_o), 1);
    for (int i = 2; i <= 32; i++) begin
      @(posedge clk); #1;
      chk("t1_dat", 32'(dat_o), 32'(i));
      chk("t1_cyc_hold", 32'(cyc_o), 1);
    end
    @(posedge clk); #1;
    chk("t1_cyc_fall", 32'(cyc_o), 0);
    chk("t1_done", 32'(done_o), 1);
    @(posedge clk); #1;
    chk("t1_done_once", 32'(done_o), 0);
    chk("t1_level0", 32'(level_o), 0);
    wait_idle();

    // Back-to-back bursts across the 16-bit address wrap
    @(negedge clk); start = 1'b1; start_adr = 16'hFFF0;
    @(negedge clk); start = 1'b0;
    a1 = '0; a2 = '0; low = 0;
    fork
      begin
        for (int i = 0; i < 64; i++) push_word(16'(200 + i));
        @(negedge clk); s_valid = 1'b0;
      end
      begin
        wait_cyc(1'b1, "t2_rise1");
        a1 = adr_o;
        wait_cyc(1'b0, "t2_fall1");
        do begin
          low++;
          @(posedge clk); #1;
        end while (cyc_o !== 1'b1 && low < 100);
        a2 = adr_o;
      end
    join
    chk("t2_adr1", 32'(a1), 32'hFFF0);
    chk("t2_adr2", 32'(a2), 32'h0010);
    chk("t2_gap", 32'(low), 32'(GAP + 1));
    wait_idle();

    // Flush a partial burst, then flush with an empty FIFO
    for (int i = 0; i < 5; i++) push_word(16'(300 + i));
    @(negedge clk); s_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_cyc(1'b1, "t3_rise");
    beats = 0; nz = 0;
    while (cyc_o === 1'b1 && beats < 100) begin
      if (dat_o != 16'h0) nz++;
      beats++;
      @(posedge clk); #1;
    end
    chk("t3_beats", 32'(beats), 32);
    chk("t3_real", 32'(nz), 5);
    wait_idle();
    chk("t3_level", 32'(level_o), 0);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    highs = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (cyc_o) highs++;
    end
    chk("t3_no_burst", 32'(highs), 0);

    // Sustained input until the FIFO fills and backpressures
    seen_full = 1'b0; push_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) push_word(16'(1000 + i));
        @(negedge clk); s_valid = 1'b0;
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          @(posedge clk); #1;
          if (!s_ready && level_o == 7'd64) seen_full = 1'b1;
        end
      end
    join
    chk("t4_full_seen", 32'(seen_full), 1);
    drain();

    // Reset in the middle of a burst
    for (int i = 0; i < 32; i++) push_word(16'(500 + i));
    @(negedge clk); s_valid = 1'b0;
    wait_cyc(1'b1, "t5_rise");
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_cyc_async", 32'(cyc_o), 0);
    chk("t5_stb_async", 32'(stb_o), 0);
    chk("t5_we_async", 32'(we_o), 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("t5_level", 32'(level_o), 0);
    chk("t5_ready", 32'(s_ready), 1);
    for (int i = 0; i < 32; i++) push_word(16'(600 + i));
    @(negedge clk); s_valid = 1'b0;
    wait_cyc(1'b1, "t5_rise2");
    chk("t5_adr0", 32'(adr_o), 0);
    chk("t5_dat", 32'(dat_o), 600);
    wait_idle();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      s_valid   = ($urandom_range(0, 3) != 0);
      s_dat     = 16'($urandom);
      flush     = ($urandom_range(0, 59) == 0);
      start     = ($urandom_range(0, 96) == 0);
      start_adr = 16'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b0; flush = 1'b0; start = 1'b0;
    drain();

    repeat (5) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
